// File: rtl/debug_hart_ctl.sv
// Debug-mode hart controller: one halt/command/resume FSM per hart, driven by
// the debug module's halt, resume and abstract-command requests.
module debug_hart_ctl #(
    parameter  int NHARTS = 1,
    parameter  int TMO_W  = 8,
    localparam int HSW    = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [HSW-1:0]        hartsel,
    input  logic                  halt_req,
    input  logic                  resume_req,
    input  logic                  exec,
    input  logic                  postexec,
    input  logic [NHARTS-1:0]     core_halted_ack,
    input  logic [NHARTS-1:0]     core_abstract_done,
    input  logic [NHARTS-1:0]     core_ebreak,
    input  logic [NHARTS-1:0]     core_fault,
    input  logic [NHARTS-1:0]     core_retire,
    input  logic [NHARTS-1:0]     step_en,
    output logic [NHARTS-1:0]     halt_ctrl,
    output logic [NHARTS-1:0]     dbg_mode,
    output logic [NHARTS-1:0]     abstract_go,
    output logic [NHARTS-1:0]     progbuf_go,
    output logic [3*NHARTS-1:0]   cause,
    output logic [NHARTS-1:0]     cause_we,
    output logic [NHARTS-1:0]     halted,
    output logic [NHARTS-1:0]     resumeack,
    output logic                  done,
    output logic                  err,
    output logic                  busy_err
);

    typedef enum logic [2:0] {
        S_RUN, S_HALTING, S_HALTED, S_ABSTRACT, S_PROGBUF, S_RESUMING, S_STEP
    } state_t;

    localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;

    function automatic logic is_stalled(state_t s);
        return s inside {S_HALTING, S_HALTED, S_ABSTRACT, S_PROGBUF, S_RESUMING};
    endfunction

    function automatic logic is_debug(state_t s);
        return s inside {S_HALTED, S_ABSTRACT, S_PROGBUF, S_RESUMING};
    endfunction

    logic              sel_ok;
    logic [NHARTS-1:0] exec_hit;
    logic [NHARTS-1:0] done_v;
    logic [NHARTS-1:0] err_v;
    logic              busy_q;

    assign sel_ok   = 32'(hartsel) < NHARTS;
    assign done     = |done_v;
    assign err      = |err_v;
    assign busy_err = busy_q;

    // A rejected exec leaves every hart untouched; only the strobe fires.
    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= 1'b0;
        else        busy_q <= exec && !(|exec_hit);
    end

    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        state_t           st, nxt;
        logic [TMO_W-1:0] tmo;
        logic [2:0]       cause_q, cause_nxt;
        logic             pe, sel, fault;
        logic             go_a, go_p, cwe, dn, er, rack;
        logic             hc_q, dbg_q, hlt_q, ago_q, pgo_q, cwe_q, dn_q, er_q, rack_q;

        assign sel         = sel_ok && (hartsel == HSW'(h));
        // Resume wins over exec when both target a halted hart.
        assign exec_hit[h] = exec && sel && !resume_req && (st == S_HALTED);
        assign fault       = core_fault[h] || (&tmo);

        // NOTE: every combinational output gets a default first so no latch is inferred.
        always_comb begin
            nxt       = st;
            cause_nxt = cause_q;
            go_a      = 1'b0;
            go_p      = 1'b0;
            cwe       = 1'b0;
            dn        = 1'b0;
            er        = 1'b0;
            rack      = 1'b0;
            case (st)
                S_RUN, S_STEP: begin
                    if (core_ebreak[h]) begin
                        nxt       = S_HALTING;
                        cause_nxt = CAUSE_EBREAK;
                    end else if (sel && halt_req) begin
                        nxt       = S_HALTING;
                        cause_nxt = CAUSE_HALTREQ;
                    end else if (st == S_STEP && core_retire[h]) begin
                        nxt       = S_HALTING;
                        cause_nxt = CAUSE_STEP;
                    end
                end
                S_HALTING: begin
                    if (core_halted_ack[h]) begin
                        nxt = S_HALTED;
                        cwe = 1'b1;
                    end
                end
                S_HALTED: begin
                    if (sel && resume_req) begin
                        nxt  = S_RESUMING;
                        rack = 1'b1;
                    end else if (exec_hit[h]) begin
                        nxt  = S_ABSTRACT;
                        go_a = 1'b1;
                    end
                end
                S_ABSTRACT: begin
                    // Fault outranks completion so a coincident pair yields one done.
                    if (fault) begin
                        nxt = S_HALTED;
                        dn  = 1'b1;
                        er  = 1'b1;
                    end else if (core_abstract_done[h]) begin
                        if (pe) begin
                            nxt  = S_PROGBUF;
                            go_p = 1'b1;
                        end else begin
                            nxt = S_HALTED;
                            dn  = 1'b1;
                        end
                    end
                end
                S_PROGBUF: begin
                    if (fault) begin
                        nxt = S_HALTED;
                        dn  = 1'b1;
                        er  = 1'b1;
                    end else if (core_ebreak[h]) begin
                        nxt = S_HALTED;
                        dn  = 1'b1;
                    end
                end
                S_RESUMING: nxt = step_en[h] ? S_STEP : S_RUN;
                default:    nxt = S_RUN;
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st      <= S_RUN;
                cause_q <= '0;
                tmo     <= '0;
                pe      <= 1'b0;
                hc_q    <= 1'b0;
                dbg_q   <= 1'b0;
                hlt_q   <= 1'b0;
                ago_q   <= 1'b0;
                pgo_q   <= 1'b0;
                cwe_q   <= 1'b0;
                dn_q    <= 1'b0;
                er_q    <= 1'b0;
                rack_q  <= 1'b0;
            end else begin
                st      <= nxt;
                cause_q <= cause_nxt;
                if (go_a) begin
                    pe  <= postexec;
                    tmo <= '0;
                end else if ((st == S_ABSTRACT || st == S_PROGBUF) && !(&tmo)) begin
                    tmo <= tmo + 1'b1;
                end
                hc_q    <= is_stalled(nxt);
                dbg_q   <= is_debug(nxt);
                hlt_q   <= (nxt == S_HALTED);
                ago_q   <= go_a;
                pgo_q   <= go_p;
                cwe_q   <= cwe;
                dn_q    <= dn;
                er_q    <= er;
                rack_q  <= rack;
            end
        end

        assign halt_ctrl[h]     = hc_q;
        assign dbg_mode[h]      = dbg_q;
        assign halted[h]        = hlt_q;
        assign abstract_go[h]   = ago_q;
        assign progbuf_go[h]    = pgo_q;
        assign cause_we[h]      = cwe_q;
        assign resumeack[h]     = rack_q;
        assign cause[3*h +: 3]  = cause_q;
        assign done_v[h]        = dn_q;
        assign err_v[h]         = er_q;
    end

endmodule

// File: doc/debug_hart_ctl.md
DEBUG_HART_CTL -- requirements
Module: debug_hart_ctl

Interface
REQ-001 SHALL have parameter NHARTS, default 1: number of harts controlled (1..16).
REQ-002 SHALL have parameter TMO_W, default 8: width of the abstract/progbuf timeout counter.
REQ-003 SHALL define HSW = max(1, clog2(NHARTS)).
REQ-004 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- hartsel  in  HSW  selected hart for DM requests.
- halt_req  in  1  level halt request to the selected hart.
- resume_req  in  1  resume pulse to the selected hart.
- exec  in  1  abstract command start pulse.
- postexec  in  1  run the program buffer after the abstract part; sampled with exec.
- core_halted_ack  in  NHARTS  the hart's pipeline is drained and stopped.
- core_abstract_done  in  NHARTS  abstract part complete.
- core_ebreak  in  NHARTS  ebreak retired.
- core_fault  in  NHARTS  exception taken while in debug.
- core_retire  in  NHARTS  instruction retired.
- step_en  in  NHARTS  dcsr.step.
- halt_ctrl  out  NHARTS  stall fetch.
- dbg_mode  out  NHARTS  hart is in debug mode.
- abstract_go  out  NHARTS  one-cycle start of the abstract part.
- progbuf_go  out  NHARTS  one-cycle start of program buffer execution.
- cause  out  3*NHARTS  dcsr.cause value.
- cause_we  out  NHARTS  one-cycle write strobe for cause.
- halted  out  NHARTS  hart is in the HALTED state.
- resumeack  out  NHARTS  one-cycle resume acknowledge.
- done  out  1  one-cycle command completion pulse.
- err  out  1  one-cycle pulse; the command failed.
- busy_err  out  1  one-cycle pulse; exec was rejected.

Function
REQ-005 SHALL keep one independent FSM per hart with states RUN, HALTING, HALTED, ABSTRACT, PROGBUF, RESUMING, STEP.
REQ-006 In RUN or STEP, halt_req with hartsel==h, or core_ebreak[h], SHALL move hart h to HALTING on the next cycle.
REQ-007 In STEP, core_retire[h] SHALL move hart h to HALTING with cause 4.
REQ-008 The cause latched on entry to HALTING SHALL follow the priority ebreak (1) > haltreq (3) > step (4).
REQ-009 In HALTING, core_halted_ack[h] SHALL move hart h to HALTED and pulse cause_we[h] for one cycle with cause[3h+:3] valid.
REQ-010 halt_ctrl[h] SHALL be 1 in HALTING, HALTED, ABSTRACT, PROGBUF and RESUMING.
REQ-011 dbg_mode[h] SHALL be 1 in HALTED, ABSTRACT, PROGBUF and RESUMING; it SHALL be 0 in HALTING.
REQ-012 exec while the selected hart is HALTED SHALL move it to ABSTRACT, pulse abstract_go on the next cycle, latch postexec, and clear the timeout counter.
REQ-013 In ABSTRACT, core_abstract_done SHALL:
- with postexec latched: go to PROGBUF and pulse progbuf_go;
- otherwise: go to HALTED and pulse done.
REQ-014 In PROGBUF, core_ebreak SHALL return the hart to HALTED and pulse done.
REQ-015 core_fault in ABSTRACT or PROGBUF SHALL return the hart to HALTED and pulse done and err together.
REQ-016 The timeout counter SHALL increment each cycle in ABSTRACT or PROGBUF and saturate at all-ones; reaching all-ones SHALL be treated as core_fault.
REQ-017 In ABSTRACT or PROGBUF, core_ebreak SHALL NOT produce cause_we.
REQ-018 exec when the selected hart is not HALTED, or when hartsel >= NHARTS, SHALL pulse busy_err and change no state.
REQ-019 resume_req while the selected hart is HALTED SHALL move it to RESUMING; resume_req in any other state SHALL be ignored.
REQ-020 RESUMING SHALL last exactly one cycle, pulse resumeack, then go to STEP if step_en[h] else RUN.
REQ-021 halt_req in RESUMING SHALL be held; the hart SHALL go RESUMING -> RUN/STEP -> HALTING.
REQ-022 If halt_req and resume_req are both asserted in RUN, halt SHALL win; in HALTED, resume SHALL win.
REQ-023 A fault that coincides with done SHALL produce one done pulse, not two.

Reset
REQ-024 rst_n low at a clock edge SHALL put every hart in RUN, even mid-command.
REQ-025 During reset, all outputs SHALL be 0, cause SHALL be 0, and the counters SHALL be cleared.
REQ-026 A command in flight at reset SHALL produce no done or err pulse.

Verification
REQ-027 NHARTS=2, hartsel=1, halt_req=1, ack at cycle+3 -> halt_ctrl[1]=1 one cycle after halt_req; cause_we[1] pulses; cause=3; halted=2'b10.
REQ-028 Halted hart, exec with postexec=1, abstract_done, then core_ebreak -> abstract_go, progbuf_go, then done pulse; err=0; hart back in HALTED.
REQ-029 Halted hart, exec, no completion for 255 cycles (TMO_W=8) -> done=1 and err=1 in the same cycle; state HALTED.
REQ-030 step_en=1, resume_req, one core_retire -> resumeack, then STEP, HALTING, cause=4.
REQ-031 exec while the hart is in RUN -> busy_err=1 for one cycle; no go pulse.
REQ-032 rst_n low during PROGBUF -> next cycle: all outputs 0, state RUN, no done.
